// File: rtl/add_and_or_if.sv
// Operand/result bundle for the ADD/AND/OR execution slice.
// master drives operands and control; slave returns the registered result and flags.
interface add_and_or_if #(
    parameter int WIDTH = 64
);
    logic             valid_in;
    logic [3:0]       control;
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] rs2;
    logic             cin;
    logic [WIDTH-1:0] rd;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             illegal;
    logic             valid_out;

    modport master (
        output valid_in, control, rs1, rs2, cin,
        input  rd, zero, carry, overflow, illegal, valid_out
    );

    modport slave (
        input  valid_in, control, rs1, rs2, cin,
        output rd, zero, carry, overflow, illegal, valid_out
    );
endinterface

// File: rtl/add_and_or_unit.sv
// Registered ADD/AND/OR slice of the execute-stage ALU; one-cycle latency,
// ripple-carry adder feeding the output register, with zero/carry/overflow/illegal flags.
module add_and_or_unit #(
    parameter int WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    add_and_or_if.slave bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;

    logic [WIDTH-1:0] sum;
    logic             sum_cout;
    logic [WIDTH-1:0] res_next;
    logic             carry_next;
    logic             ovf_next;
    logic             ill_next;
    logic             zero_next;

    // Ripple chain of full-adder cells; the running carry is a loop-local variable.
    always_comb begin
        logic c;
        c   = bus.cin;
        sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = bus.rs1[i] ^ bus.rs2[i] ^ c;
            c      = (bus.rs1[i] & bus.rs2[i]) | (c & (bus.rs1[i] ^ bus.rs2[i]));
        end
        sum_cout = c;
    end

    always_comb begin
        res_next   = '0;
        carry_next = 1'b0;
        ovf_next   = 1'b0;
        ill_next   = 1'b0;
        case (bus.control)
            OP_AND: res_next = bus.rs1 & bus.rs2;
            OP_OR:  res_next = bus.rs1 | bus.rs2;
            OP_ADD: begin
                res_next   = sum;
                carry_next = sum_cout;
                ovf_next   = (bus.rs1[WIDTH-1] == bus.rs2[WIDTH-1]) &&
                             (sum[WIDTH-1] != bus.rs1[WIDTH-1]);
            end
            default: ill_next = 1'b1;
        endcase
        // An illegal op forces rd to zero but must not report zero.
        zero_next = (res_next == '0) && !ill_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd        <= '0;
            bus.zero      <= 1'b0;
            bus.carry     <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.illegal   <= 1'b0;
            bus.valid_out <= 1'b0;
        end else if (bus.valid_in) begin
            bus.rd        <= res_next;
            bus.zero      <= zero_next;
            bus.carry     <= carry_next;
            bus.overflow  <= ovf_next;
            bus.illegal   <= ill_next;
            bus.valid_out <= 1'b1;
        end else begin
            bus.valid_out <= 1'b0;
        end
    end
endmodule

// File: tb/tb_add_and_or_unit.sv
// Directed plus short random bench for add_and_or_unit: expectations are queued
// when stimulus is driven and popped one cycle later when the outputs are sampled.
module tb_add_and_or_unit;
    localparam int W = 64;
    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;

    typedef struct {
        logic [W-1:0] rd;
        logic         zero;
        logic         carry;
        logic         overflow;
        logic         illegal;
        logic         valid;
        string        tag;
    } exp_t;

    logic clk;
    logic rst;
    int   total  = 0;
    int   passed = 0;
    exp_t sbq[$];
    exp_t last;

    add_and_or_if #(.WIDTH(W)) bus ();

    add_and_or_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs and queue the outputs they must produce after the next edge.
    task automatic drive(input string tag, input logic r, input logic v, input logic [3:0] ctl,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        exp_t e;
        logic [W:0] ufull;
        logic [W:0] sfull;
        rst          = r;
        bus.valid_in = v;
        bus.control  = ctl;
        bus.rs1      = a;
        bus.rs2      = b;
        bus.cin      = ci;
        e     = last;
        e.tag = tag;
        if (r) begin
            e.rd = '0; e.zero = 0; e.carry = 0; e.overflow = 0; e.illegal = 0; e.valid = 0;
        end else if (!v) begin
            e.valid = 0;
        end else begin
            e.carry = 0; e.overflow = 0; e.illegal = 0; e.valid = 1;
            if (ctl == C_AND) e.rd = a & b;
            else if (ctl == C_OR) e.rd = a | b;
            else if (ctl == C_ADD) begin
                ufull = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
                sfull = {a[W-1], a} + {b[W-1], b} + {{W{1'b0}}, ci};
                e.rd       = ufull[W-1:0];
                e.carry    = ufull[W];
                e.overflow = (sfull[W] != sfull[W-1]);
            end else begin
                e.rd = '0;
                e.illegal = 1;
            end
            e.zero = !e.illegal && (e.rd == '0);
        end
        last = e;
        sbq.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            total++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sbq.pop_front();
            chk({e.tag, ".valid_out"}, W'(bus.valid_out), W'(e.valid));
            chk({e.tag, ".rd"},        bus.rd,            e.rd);
            chk({e.tag, ".zero"},      W'(bus.zero),      W'(e.zero));
            chk({e.tag, ".carry"},     W'(bus.carry),     W'(e.carry));
            chk({e.tag, ".overflow"},  W'(bus.overflow),  W'(e.overflow));
            chk({e.tag, ".illegal"},   W'(bus.illegal),   W'(e.illegal));
        end
    endtask

    task automatic op(input string tag, input logic [3:0] ctl, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic ci);
        drive(tag, 1'b0, 1'b1, ctl, a, b, ci);
        tick();
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [3:0]   rc;
        last = '{rd: '0, zero: 0, carry: 0, overflow: 0, illegal: 0, valid: 0, tag: "init"};

        drive("reset0", 1'b1, 1'b1, C_ADD, 64'd5, 64'd7, 1'b0); tick();
        drive("reset1", 1'b1, 1'b1, C_ADD, 64'd5, 64'd7, 1'b0); tick();

        op("add_5_7",     C_ADD, 64'd5, 64'd7, 1'b0);
        op("add_m1_1",    C_ADD, '1, 64'd1, 1'b0);
        op("add_maxpos",  C_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        op("add_minneg",  C_ADD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        op("add_cin",     C_ADD, 64'd10, 64'd20, 1'b1);
        op("add_m1_0cin", C_ADD, '1, 64'd0, 1'b1);
        op("add_negneg",  C_ADD, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);

        op("and_f0f0",    C_AND, 64'hF0F0, 64'h0FF0, 1'b1);
        op("and_zero",    C_AND, 64'hF0, 64'h0F, 1'b0);
        op("or_ff",       C_OR,  64'hF0, 64'h0F, 1'b1);
        op("or_zero",     C_OR,  64'd0, 64'd0, 1'b0);

        op("b2b_add",     C_ADD, 64'd1, 64'd2, 1'b0);
        op("b2b_and",     C_AND, 64'd3, 64'd6, 1'b0);
        op("b2b_or",      C_OR,  64'd4, 64'd1, 1'b0);
        drive("hold0", 1'b0, 1'b0, C_ADD, '1, '1, 1'b1); tick();
        drive("hold1", 1'b0, 1'b0, C_AND, 64'd0, 64'd0, 1'b0); tick();

        op("pre_ill_add", C_ADD, '1, 64'd2, 1'b0);
        op("illegal_6",   4'b0110, '1, '1, 1'b1);
        op("illegal_f",   4'b1111, 64'd0, 64'd0, 1'b0);
        op("post_ill_or", C_OR,  64'h1234, 64'd0, 1'b0);

        op("pre_rst_add", C_ADD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
        drive("mid_rst",  1'b1, 1'b1, C_ADD, 64'd9, 64'd9, 1'b0); tick();
        drive("after_rst", 1'b0, 1'b0, C_ADD, 64'd9, 64'd9, 1'b0); tick();

        for (int i = 0; i < 40; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            rc = 4'($urandom_range(0, 3));
            if (i % 4 == 0) rb = ~ra;
            drive($sformatf("rand%0d", i), 1'b0, (i % 7 != 3), rc, ra, rb, 1'($urandom_range(0, 1)));
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
